alu_writeback_ctrl: RTL

ALU_WRITEBACK_CTRL -- requirements
Module: alu_writeback_ctrl

---
 rtl/alu_writeback_ctrl.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/alu_writeback_ctrl.sv
// Sequencing controller for one ALU operation: read two registers, execute, write back.
// Runs a fixed IDLE -> READ -> EXEC -> WRITE walk per accepted command.
module alu_writeback_ctrl #(
    parameter int DATA_W = 8,
    parameter int SEL_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [SEL_W-1:0]  cmd_srcA,
    input  logic [SEL_W-1:0]  cmd_srcB,
    input  logic [SEL_W-1:0]  cmd_dst,
    output logic [SEL_W-1:0]  A_sel,
    output logic [SEL_W-1:0]  B_sel,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    output logic [DATA_W-1:0] replaceData,
    output logic [SEL_W-1:0]  replaceSel,
    output logic              replaceEn,
    output logic              done,
    output logic              carry,
    output logic              zero,
    output logic [1:0]        dbg_state
);

    // Handshake: a command transfers on a rising edge where cmd_valid and cmd_ready
    // are both high; cmd_ready is high only in IDLE, and fields are ignored otherwise.

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_EXEC  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_MOV = 3'd7;

    state_t              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [SEL_W-1:0]    dst_q, dst_d;
    logic [SEL_W-1:0]    a_sel_q, a_sel_d;
    logic [SEL_W-1:0]    b_sel_q, b_sel_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [DATA_W-1:0]   replace_data_q, replace_data_d;
    logic [SEL_W-1:0]    replace_sel_q, replace_sel_d;
    logic                replace_en_q, replace_en_d;
    logic                done_q, done_d;
    logic                carry_q, carry_d;
    logic                zero_q, zero_d;
    logic                cmd_ready_q, cmd_ready_d;

    logic [DATA_W-1:0]   alu_res;
    logic                alu_carry;

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        case (op_q)
            OP_ADD: {alu_carry, alu_res} = {1'b0, a_q} + {1'b0, b_q};
            OP_SUB: begin
                alu_res   = a_q - b_q;
                alu_carry = (a_q < b_q);
            end
            OP_AND: alu_res = a_q & b_q;
            OP_OR:  alu_res = a_q | b_q;
            OP_XOR: alu_res = a_q ^ b_q;
            OP_SHL: begin
                alu_res   = {a_q[DATA_W-2:0], 1'b0};
                alu_carry = a_q[DATA_W-1];
            end
            OP_SHR: begin
                alu_res   = {1'b0, a_q[DATA_W-1:1]};
                alu_carry = a_q[0];
            end
            OP_MOV: alu_res = a_q;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        dst_d          = dst_q;
        a_sel_d        = a_sel_q;
        b_sel_d        = b_sel_q;
        a_d            = a_q;
        b_d            = b_q;
        replace_data_d = replace_data_q;
        replace_sel_d  = replace_sel_q;
        replace_en_d   = 1'b0;
        done_d         = 1'b0;
        carry_d        = carry_q;
        zero_d         = zero_q;
        cmd_ready_d    = cmd_ready_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    op_d        = cmd_op;
                    dst_d       = cmd_dst;
                    a_sel_d     = cmd_srcA;
                    b_sel_d     = cmd_srcB;
                    cmd_ready_d = 1'b0;
                    state_d     = S_READ;
                end
            end
            S_READ: begin
                a_d     = A;
                b_d     = B;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                // Outputs for the WRITE cycle are loaded here so they are flop-driven.
                replace_data_d = alu_res;
                replace_sel_d  = dst_q;
                replace_en_d   = 1'b1;
                done_d         = 1'b1;
                carry_d        = alu_carry;
                zero_d         = (alu_res == '0);
                state_d        = S_WRITE;
            end
            S_WRITE: begin
                cmd_ready_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: begin
                cmd_ready_d = 1'b1;
                state_d     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            op_q           <= '0;
            dst_q          <= '0;
            a_sel_q        <= '0;
            b_sel_q        <= '0;
            a_q            <= '0;
            b_q            <= '0;
            replace_data_q <= '0;
            replace_sel_q  <= '0;
            replace_en_q   <= 1'b0;
            done_q         <= 1'b0;
            carry_q        <= 1'b0;
            zero_q         <= 1'b0;
            cmd_ready_q    <= 1'b1;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            dst_q          <= dst_d;
            a_sel_q        <= a_sel_d;
            b_sel_q        <= b_sel_d;
            a_q            <= a_d;
            b_q            <= b_d;
            replace_data_q <= replace_data_d;
            replace_sel_q  <= replace_sel_d;
            replace_en_q   <= replace_en_d;
            done_q         <= done_d;
            carry_q        <= carry_d;
            zero_q         <= zero_d;
            cmd_ready_q    <= cmd_ready_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign A_sel       = a_sel_q;
    assign B_sel       = b_sel_q;
    assign replaceData = replace_data_q;
    assign replaceSel  = replace_sel_q;
    assign replaceEn   = replace_en_q;
    assign done        = done_q;
    assign carry       = carry_q;
    assign zero        = zero_q;
    assign dbg_state   = state_q;

endmodule
